// File: rtl/conn_table_search_if.sv
// Request/response bundle for conn_table_search; the stats outputs exist only when CT_STATS_EN is defined.
interface conn_table_search_if #(
    parameter int DEPTH  = 256,
    parameter int MAC_W  = 48,
    parameter int IP_W   = 32,
    parameter int PORT_W = 16
);
    localparam int ID_W = $clog2(DEPTH);

    logic              ct_req_valid;
    logic              ct_req_ready;
    logic [1:0]        ct_req_op;
    logic [ID_W-1:0]   ct_id_in;
    logic [MAC_W-1:0]  ct_mac_src;
    logic [MAC_W-1:0]  ct_mac_dst;
    logic [IP_W-1:0]   ct_ip_src;
    logic [IP_W-1:0]   ct_ip_dst;
    logic [PORT_W-1:0] ct_port_src;
    logic [PORT_W-1:0] ct_port_dst;
    logic              ct_rsp_valid;
    logic              ct_rsp_ready;
    logic [ID_W-1:0]   ct_rsp_id;
    logic [7:0]        ct_rsp_status;
    logic [ID_W:0]     ct_count;
`ifdef CT_STATS_EN
    logic [15:0]       ct_stat_hits;
    logic [15:0]       ct_stat_inserts;
    logic [15:0]       ct_stat_full;
`endif

    modport master (
        output ct_req_valid, ct_req_op, ct_id_in, ct_mac_src, ct_mac_dst,
               ct_ip_src, ct_ip_dst, ct_port_src, ct_port_dst, ct_rsp_ready,
        input  ct_req_ready, ct_rsp_valid, ct_rsp_id, ct_rsp_status, ct_count
`ifdef CT_STATS_EN
        , input ct_stat_hits, ct_stat_inserts, ct_stat_full
`endif
    );

    modport slave (
        input  ct_req_valid, ct_req_op, ct_id_in, ct_mac_src, ct_mac_dst,
               ct_ip_src, ct_ip_dst, ct_port_src, ct_port_dst, ct_rsp_ready,
        output ct_req_ready, ct_rsp_valid, ct_rsp_id, ct_rsp_status, ct_count
`ifdef CT_STATS_EN
        , output ct_stat_hits, ct_stat_inserts, ct_stat_full
`endif
    );
endinterface

// File: rtl/conn_table_search.sv
// Connection table: OPEN/LOOKUP scan the key RAM sequentially, CLOSE invalidates by ID (CT_STATS_EN adds counters).
// Latency: hit at i -> i+3, miss -> DEPTH+2 (DEPTH+3 with insert), CLOSE/illegal -> 1 edge after accept.
// Backpressure: one request in flight; ct_req_ready only in IDLE, response held until ct_rsp_ready.
module conn_table_search #(
    parameter int DEPTH  = 256,
    parameter int MAC_W  = 48,
    parameter int IP_W   = 32,
    parameter int PORT_W = 16
) (
    input  logic               ct_clk,
    input  logic               ct_rst_n,
    conn_table_search_if.slave bus
);
    localparam int ID_W  = $clog2(DEPTH);
    localparam int KEY_W = 2*(MAC_W+IP_W+PORT_W);
    localparam int SLOTS = 1 << ID_W;
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(DEPTH-1);

    localparam logic [1:0] OP_OPEN   = 2'b01;
    localparam logic [1:0] OP_CLOSE  = 2'b10;
    localparam logic [1:0] OP_LOOKUP = 2'b11;

    localparam logic [7:0] ST_INSERTED  = 8'h00;
    localparam logic [7:0] ST_EXISTS    = 8'h01;
    localparam logic [7:0] ST_NOT_FOUND = 8'h02;
    localparam logic [7:0] ST_FULL      = 8'h03;
    localparam logic [7:0] ST_BAD_ID    = 8'h04;
    localparam logic [7:0] ST_BAD_OP    = 8'h05;

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_SCAN, S_WRITE, S_RESP} state_t;

    state_t r_state, w_state_nxt;

    logic              r_live;
    logic [1:0]        r_op;
    logic [ID_W-1:0]   r_id;
    logic [KEY_W-1:0]  r_key;
    logic [KEY_W-1:0]  r_mem [DEPTH];
    logic [KEY_W-1:0]  r_q;
    logic [SLOTS-1:0]  r_valid;
    logic [ID_W:0]     r_count;
    logic [ID_W-1:0]   r_addr;
    logic              r_issue;
    logic              r_p1_act, r_p1_vld, r_p1_last;
    logic [ID_W-1:0]   r_p1_idx;
    logic              r_p2_act, r_p2_match, r_p2_last;
    logic [ID_W-1:0]   r_p2_idx;
    logic              r_free_found;
    logic [ID_W-1:0]   r_free_slot;
    logic              r_rsp_valid;
    logic [ID_W-1:0]   r_rsp_id;
    logic [7:0]        r_rsp_status;

    logic              w_req_ready, w_accept, w_rsp_load, w_close, w_insert, w_id_ok;
    logic [ID_W-1:0]   w_rsp_id;
    logic [7:0]        w_rsp_status;

    assign w_req_ready = r_live && (r_state == S_IDLE);
    assign w_id_ok     = (int'(r_id) < DEPTH) && r_valid[r_id];

    always_ff @(posedge ct_clk or negedge ct_rst_n) begin
        if (!ct_rst_n) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_rsp_load   = 1'b0;
        w_close      = 1'b0;
        w_insert     = 1'b0;
        w_rsp_id     = '0;
        w_rsp_status = ST_INSERTED;
        unique case (r_state)
            S_IDLE: if (bus.ct_req_valid && w_req_ready) begin
                w_accept    = 1'b1;
                w_state_nxt = (bus.ct_req_op == OP_OPEN || bus.ct_req_op == OP_LOOKUP) ? S_SCAN : S_EXEC;
            end
            S_EXEC: begin
                w_rsp_load  = 1'b1;
                w_state_nxt = S_RESP;
                if (r_op != OP_CLOSE)  w_rsp_status = ST_BAD_OP;
                else if (!w_id_ok)     w_rsp_status = ST_BAD_ID;
                else begin
                    w_close  = 1'b1;
                    w_rsp_id = r_id;
                end
            end
            // Decisions come from the second pipeline stage, so the first match wins.
            S_SCAN: if (r_p2_act) begin
                if (r_p2_match) begin
                    w_rsp_load   = 1'b1;
                    w_rsp_status = ST_EXISTS;
                    w_rsp_id     = r_p2_idx;
                    w_state_nxt  = S_RESP;
                end else if (r_p2_last) begin
                    if (r_op == OP_LOOKUP) begin
                        w_rsp_load   = 1'b1;
                        w_rsp_status = ST_NOT_FOUND;
                        w_state_nxt  = S_RESP;
                    end else if (r_free_found) begin
                        w_state_nxt  = S_WRITE;
                    end else begin
                        w_rsp_load   = 1'b1;
                        w_rsp_status = ST_FULL;
                        w_state_nxt  = S_RESP;
                    end
                end
            end
            S_WRITE: begin
                w_insert     = 1'b1;
                w_rsp_load   = 1'b1;
                w_rsp_status = ST_INSERTED;
                w_rsp_id     = r_free_slot;
                w_state_nxt  = S_RESP;
            end
            S_RESP: if (bus.ct_rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ct_clk) begin
        if (w_insert) r_mem[r_free_slot] <= r_key;
        r_q <= r_mem[r_addr];
    end

    always_ff @(posedge ct_clk or negedge ct_rst_n) begin
        if (!ct_rst_n) begin
            r_live       <= 1'b0;
            r_op         <= '0;
            r_id         <= '0;
            r_key        <= '0;
            r_valid      <= '0;
            r_count      <= '0;
            r_addr       <= '0;
            r_issue      <= 1'b0;
            r_p1_act     <= 1'b0;
            r_p1_vld     <= 1'b0;
            r_p1_last    <= 1'b0;
            r_p1_idx     <= '0;
            r_p2_act     <= 1'b0;
            r_p2_match   <= 1'b0;
            r_p2_last    <= 1'b0;
            r_p2_idx     <= '0;
            r_free_found <= 1'b0;
            r_free_slot  <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_status <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_accept) begin
                r_op         <= bus.ct_req_op;
                r_id         <= bus.ct_id_in;
                r_key        <= {bus.ct_mac_src, bus.ct_mac_dst, bus.ct_ip_src,
                                 bus.ct_ip_dst, bus.ct_port_src, bus.ct_port_dst};
                r_addr       <= '0;
                r_issue      <= 1'b1;
                r_free_found <= 1'b0;
            end else if (r_state == S_SCAN && r_issue) begin
                r_addr <= r_addr + ID_W'(1);
                if (r_addr == LAST_IDX) r_issue <= 1'b0;
            end

            r_p1_act   <= (r_state == S_SCAN) && r_issue;
            r_p1_vld   <= r_valid[r_addr];
            r_p1_idx   <= r_addr;
            r_p1_last  <= (r_addr == LAST_IDX);
            r_p2_act   <= r_p1_act && (r_state == S_SCAN);
            r_p2_match <= r_p1_vld && (r_q == r_key);
            r_p2_idx   <= r_p1_idx;
            r_p2_last  <= r_p1_last;
            if (r_p1_act && !r_p1_vld && !r_free_found) begin
                r_free_found <= 1'b1;
                r_free_slot  <= r_p1_idx;
            end

            if (w_insert) begin
                r_valid[r_free_slot] <= 1'b1;
                if (r_count < (ID_W+1)'(DEPTH)) r_count <= r_count + 1'b1;
            end
            if (w_close) begin
                r_valid[r_id] <= 1'b0;
                if (r_count != '0) r_count <= r_count - 1'b1;
            end

            if (w_rsp_load) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_id     <= w_rsp_id;
                r_rsp_status <= w_rsp_status;
            end else if (r_rsp_valid && bus.ct_rsp_ready) begin
                r_rsp_valid  <= 1'b0;
            end
        end
    end

    assign bus.ct_req_ready  = w_req_ready;
    assign bus.ct_rsp_valid  = r_rsp_valid;
    assign bus.ct_rsp_id     = r_rsp_id;
    assign bus.ct_rsp_status = r_rsp_status;
    assign bus.ct_count      = r_count;

`ifdef CT_STATS_EN
    logic [15:0] r_stat_hits, r_stat_inserts, r_stat_full;

    always_ff @(posedge ct_clk or negedge ct_rst_n) begin
        if (!ct_rst_n) begin
            r_stat_hits    <= '0;
            r_stat_inserts <= '0;
            r_stat_full    <= '0;
        end else if (w_rsp_load) begin
            if (w_rsp_status == ST_EXISTS && r_stat_hits != 16'hFFFF)
                r_stat_hits <= r_stat_hits + 16'd1;
            if (w_rsp_status == ST_INSERTED && w_insert && r_stat_inserts != 16'hFFFF)
                r_stat_inserts <= r_stat_inserts + 16'd1;
            if (w_rsp_status == ST_FULL && r_stat_full != 16'hFFFF)
                r_stat_full <= r_stat_full + 16'd1;
        end
    end

    assign bus.ct_stat_hits    = r_stat_hits;
    assign bus.ct_stat_inserts = r_stat_inserts;
    assign bus.ct_stat_full    = r_stat_full;
`endif
endmodule

// File: tb/tb_conn_table_search.sv
// Scoreboard bench for conn_table_search with a 4-entry table: directed ops, latency, hold and reset cases.
module tb_conn_table_search;
    localparam int DEPTH  = 4;
    localparam int MAC_W  = 48;
    localparam int IP_W   = 32;
    localparam int PORT_W = 16;
    localparam int ID_W   = $clog2(DEPTH);

    localparam logic [1:0] OP_ILL = 2'b00, OP_OPEN = 2'b01, OP_CLOSE = 2'b10, OP_LOOKUP = 2'b11;
    localparam logic [7:0] ST_INS = 8'h00, ST_EX = 8'h01, ST_NF = 8'h02,
                           ST_FULL = 8'h03, ST_BADID = 8'h04, ST_BADOP = 8'h05;
    localparam int N_MISS = DEPTH + 2;
    localparam int N_INS  = DEPTH + 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conn_table_search_if #(.DEPTH(DEPTH), .MAC_W(MAC_W), .IP_W(IP_W), .PORT_W(PORT_W)) bus();

    conn_table_search #(.DEPTH(DEPTH), .MAC_W(MAC_W), .IP_W(IP_W), .PORT_W(PORT_W)) dut (
        .ct_clk   (clk),
        .ct_rst_n (rst_n),
        .bus      (bus.slave)
    );

    typedef struct {
        logic [7:0]      st;
        logic [ID_W-1:0] id;
        int              n;
        int              cnt;
        int              acc;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic set_key(input int k);
        bus.ct_mac_src  = 48'h02AA_0000_0000 + 48'(k);
        bus.ct_mac_dst  = 48'h0455_0000_1000 + 48'(k * 3);
        bus.ct_ip_src   = 32'h0A00_0000 + 32'(k);
        bus.ct_ip_dst   = 32'hC0A8_0100 + 32'(k * 7);
        bus.ct_port_src = 16'(1000 + k);
        bus.ct_port_dst = 16'd80;
    endtask

    task automatic issue(input logic [1:0] op, input int k, input int id, input bit push,
                         input logic [7:0] st, input int eid, input int n, input int cnt);
        exp_t e;
        bit got;
        @(posedge clk); #1;
        bus.ct_req_op    = op;
        bus.ct_id_in     = ID_W'(id);
        set_key(k);
        bus.ct_req_valid = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (bus.ct_req_ready) begin
                got = 1'b1;
                if (push) begin
                    e.st = st; e.id = ID_W'(eid); e.n = n; e.cnt = cnt; e.acc = cyc + 1;
                    sb.push_back(e);
                end
            end
        end
        if (!got) chk("req_ready_timeout", 0, 1);
        @(posedge clk); #1;
        bus.ct_req_valid = 1'b0;
        bus.ct_req_op    = OP_ILL;
        bus.ct_id_in     = '1;
        set_key(99);
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && sb.size() != 0; t++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("rsp_timeout_pending", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic op(input logic [1:0] o, input int k, input int id,
                      input logic [7:0] st, input int eid, input int n, input int cnt);
        issue(o, k, id, 1'b1, st, eid, n, cnt);
        drain();
    endtask

    bit              seen = 1'b0;
    int              first_cyc = 0;
    logic [ID_W-1:0] f_id;
    logic [7:0]      f_st;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            seen = 1'b0;
        end else if (bus.ct_rsp_valid) begin
            if (!seen) begin
                seen = 1'b1;
                first_cyc = cyc;
                f_id = bus.ct_rsp_id;
                f_st = bus.ct_rsp_status;
            end else if (!bus.ct_rsp_ready) begin
                chk("hold_rsp_id", bus.ct_rsp_id, f_id);
                chk("hold_rsp_status", bus.ct_rsp_status, f_st);
            end
            if (!bus.ct_rsp_ready) chk("hold_req_ready", bus.ct_req_ready, 0);
            if (bus.ct_rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_status", bus.ct_rsp_status, e.st);
                    chk("rsp_id", bus.ct_rsp_id, e.id);
                    chk("rsp_latency", first_cyc - e.acc, e.n);
                    chk("count", bus.ct_count, e.cnt);
                end
                seen = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ct_req_valid = 1'b0;
        bus.ct_req_op    = OP_ILL;
        bus.ct_id_in     = '0;
        bus.ct_rsp_ready = 1'b1;
        set_key(99);

        repeat (3) @(posedge clk); #1;
        chk("reset_req_ready", bus.ct_req_ready, 0);
        chk("reset_rsp_valid", bus.ct_rsp_valid, 0);
        chk("reset_rsp_id", bus.ct_rsp_id, 0);
        chk("reset_rsp_status", bus.ct_rsp_status, 0);
        chk("reset_count", bus.ct_count, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("post_reset_req_ready", bus.ct_req_ready, 1);

        op(OP_OPEN,   0, 0, ST_INS, 0, N_INS,  1);
        op(OP_OPEN,   0, 0, ST_EX,  0, 3,      1);
        op(OP_LOOKUP, 1, 0, ST_NF,  0, N_MISS, 1);

        op(OP_OPEN,   1, 0, ST_INS,   1, N_INS, 2);
        op(OP_OPEN,   2, 0, ST_INS,   2, N_INS, 3);
        op(OP_CLOSE,  0, 1, ST_INS,   1, 1,     2);
        op(OP_CLOSE,  0, 1, ST_BADID, 0, 1,     2);
        op(OP_OPEN,   3, 0, ST_INS,   1, N_INS, 3);
        op(OP_LOOKUP, 2, 0, ST_EX,    2, 5,     3);

        // Table now holds K0,K3,K2 in slots 0..2; K4 takes the last slot.
        op(OP_OPEN,   4, 0, ST_INS,  3, N_INS,  4);
        op(OP_OPEN,   5, 0, ST_FULL, 0, N_MISS, 4);
        op(OP_LOOKUP, 4, 0, ST_EX,   3, 6,      4);
        op(OP_LOOKUP, 5, 0, ST_NF,   0, N_MISS, 4);
`ifdef CT_STATS_EN
        chk("stat_hits", bus.ct_stat_hits, 3);
        chk("stat_inserts", bus.ct_stat_inserts, 5);
        chk("stat_full", bus.ct_stat_full, 1);
`endif

        bus.ct_rsp_ready = 1'b0;
        issue(OP_LOOKUP, 0, 0, 1'b1, ST_EX, 0, 3, 4);
        repeat (12) @(posedge clk); #1;
        bus.ct_rsp_ready = 1'b1;
        drain();

        op(OP_ILL,   0, 0, ST_BADOP, 0, 1,     4);
        op(OP_CLOSE, 0, 3, ST_INS,   3, 1,     3);
        op(OP_OPEN,  5, 0, ST_INS,   3, N_INS, 4);

        issue(OP_LOOKUP, 2, 0, 1'b0, ST_EX, 0, 0, 0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midscan_rst_rsp_valid", bus.ct_rsp_valid, 0);
        chk("midscan_rst_count", bus.ct_count, 0);
        chk("midscan_rst_req_ready", bus.ct_req_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        chk("midscan_no_stale_rsp", bus.ct_rsp_valid, 0);

        op(OP_LOOKUP, 0, 0, ST_NF,  0, N_MISS, 0);
        op(OP_LOOKUP, 2, 0, ST_NF,  0, N_MISS, 0);
        op(OP_OPEN,   2, 0, ST_INS, 0, N_INS,  1);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
